systick_timer: RTL



---
 rtl/systick_pkg.sv | 28 ++
 rtl/systick_timer_if.sv | 22 ++
 rtl/systick_prescaler.sv | 30 +++
 rtl/systick_timer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/systick_pkg.sv
// rtl/systick_pkg.sv - shared constants for the system tick timer
package systick_pkg;

    localparam int CNT_W = 24;
    localparam int PSC_W = 4;
    localparam int PRE_W = 15;

    localparam logic [2:0] ADDR_CTRL = 3'd0;
    localparam logic [2:0] ADDR_RLD0 = 3'd1;
    localparam logic [2:0] ADDR_RLD1 = 3'd2;
    localparam logic [2:0] ADDR_RLD2 = 3'd3;
    localparam logic [2:0] ADDR_CNT0 = 3'd4;
    localparam logic [2:0] ADDR_CNT1 = 3'd5;
    localparam logic [2:0] ADDR_CNT2 = 3'd6;
    localparam logic [2:0] ADDR_STAT = 3'd7;

    localparam int CTRL_EN      = 7;
    localparam int CTRL_IE      = 6;
    localparam int CTRL_ONESHOT = 5;
    localparam int CTRL_PSC_LSB = 0;

    localparam int STAT_TF  = 0;
    localparam int STAT_OVR = 1;

    // Position of this timer's request on the interrupt controller's INT_ARR bus
    localparam int SYSTICK_IRQ_IDX = 6;

endpackage

// File: rtl/systick_timer_if.sv
// rtl/systick_timer_if.sv - 8-register Wishbone slave bus for the tick timer
interface systick_timer_if;

    logic [2:0] WB_ADRi;
    logic [7:0] WB_DATi;
    logic [7:0] WB_DATo;
    logic       WB_WEi;
    logic       WB_CYCi;
    logic       WB_STBi;
    logic       WB_ACKo;

    modport master (
        output WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
        input  WB_DATo, WB_ACKo
    );

    modport slave (
        input  WB_ADRi, WB_DATi, WB_WEi, WB_CYCi, WB_STBi,
        output WB_DATo, WB_ACKo
    );

endinterface

// File: rtl/systick_prescaler.sv
// rtl/systick_prescaler.sv - power-of-two prescaler producing the counter tick
module systick_prescaler
    import systick_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             clr,
    input  logic [PSC_W-1:0] psc,
    output logic             tick
);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] mask;

    // psc = 15 shifts the one out entirely, so the subtraction yields all ones
    assign mask = (PRE_W'(1) << psc) - PRE_W'(1);
    assign tick = en && ((pre_q & mask) == mask);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
        end else if (clr || !en || tick) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_q + PRE_W'(1);
        end
    end

endmodule

// File: rtl/systick_timer.sv
// rtl/systick_timer.sv - 24-bit down-counting tick timer with Wishbone register file
module systick_timer
    import systick_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    systick_timer_if.slave  wb,
    output logic            IRQ,
    output logic            TICK
);

    logic             en_q;
    logic             ie_q;
    logic             oneshot_q;
    logic [PSC_W-1:0] psc_q;
    logic [CNT_W-1:0] rld_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      shadow_q;
    logic             tf_q;
    logic             ovr_q;

    logic bus_sel;
    logic bus_wr;
    logic wr_ctrl;
    logic wr_stat;
    logic start;
    logic pre_tick;
    logic timeout;

    assign bus_sel = wb.WB_CYCi & wb.WB_STBi;
    assign bus_wr  = bus_sel & wb.WB_WEi;
    assign wr_ctrl = bus_wr && (wb.WB_ADRi == ADDR_CTRL);
    assign wr_stat = bus_wr && (wb.WB_ADRi == ADDR_STAT);
    // Only a 0->1 transition of EN reloads; rewriting EN=1 just retunes IE/ONESHOT/PSC
    assign start   = wr_ctrl && wb.WB_DATi[CTRL_EN] && !en_q;
    assign timeout = pre_tick && (cnt_q == '0);

    assign wb.WB_ACKo = bus_sel;

    systick_prescaler u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en_q),
        .clr   (start),
        .psc   (psc_q),
        .tick  (pre_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            oneshot_q <= 1'b0;
            psc_q     <= '0;
        end else if (wr_ctrl) begin
            en_q      <= wb.WB_DATi[CTRL_EN];
            ie_q      <= wb.WB_DATi[CTRL_IE];
            oneshot_q <= wb.WB_DATi[CTRL_ONESHOT];
            psc_q     <= wb.WB_DATi[CTRL_PSC_LSB +: PSC_W];
        end else if (timeout && oneshot_q) begin
            en_q      <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rld_q <= '0;
        end else if (bus_wr) begin
            case (wb.WB_ADRi)
                ADDR_RLD0: rld_q[7:0]   <= wb.WB_DATi;
                ADDR_RLD1: rld_q[15:8]  <= wb.WB_DATi;
                ADDR_RLD2: rld_q[23:16] <= wb.WB_DATi;
                default:   rld_q        <= rld_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= rld_q;
        end else if (pre_tick) begin
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end else if (!oneshot_q) begin
                cnt_q <= rld_q;
            end
        end
    end

    // A timeout landing on the same edge as a write-1-to-clear keeps the flag set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tf_q  <= 1'b0;
            ovr_q <= 1'b0;
            IRQ   <= 1'b0;
            TICK  <= 1'b0;
        end else begin
            tf_q  <= (tf_q & ~(wr_stat & wb.WB_DATi[STAT_TF])) | timeout;
            ovr_q <= (ovr_q & ~(wr_stat & wb.WB_DATi[STAT_OVR])) | (timeout & tf_q);
            IRQ   <= tf_q & ie_q;
            TICK  <= timeout;
        end
    end

    // Reading the low byte freezes the upper bytes so a multi-byte read is coherent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else if (bus_sel && !wb.WB_WEi && (wb.WB_ADRi == ADDR_CNT0)) begin
            shadow_q <= cnt_q[23:8];
        end
    end

    always_comb begin
        wb.WB_DATo = 8'h00;
        case (wb.WB_ADRi)
            ADDR_CTRL: wb.WB_DATo = {en_q, ie_q, oneshot_q, 1'b0, psc_q};
            ADDR_RLD0: wb.WB_DATo = rld_q[7:0];
            ADDR_RLD1: wb.WB_DATo = rld_q[15:8];
            ADDR_RLD2: wb.WB_DATo = rld_q[23:16];
            ADDR_CNT0: wb.WB_DATo = cnt_q[7:0];
            ADDR_CNT1: wb.WB_DATo = shadow_q[7:0];
            ADDR_CNT2: wb.WB_DATo = shadow_q[15:8];
            ADDR_STAT: wb.WB_DATo = {6'b0, ovr_q, tf_q};
            default:   wb.WB_DATo = 8'h00;
        endcase
    end

endmodule
